// File: rtl/gen3_scramble_ctrl.sv
// Gen3 (128b/130b) per-lane scrambler sequencer.
// Takes one byte per cycle from block framing, chooses per byte whether to
// scramble and how the 23-bit LFSR moves (advance, hold or reseed), and
// presents the result through a one-deep output register to the serializer.
//
// Handshake: a byte moves on a side when its valid and ready are both high at
// a rising clock edge; a source holds valid and its payload steady until that
// happens, and ready may depend combinationally on the downstream ready.
module gen3_scramble_ctrl #(
    parameter int LANE_NUM = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_scramble_disable,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic [1:0]  s_sync,
    input  logic        s_block_start,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    output logic [1:0]  m_sync,
    output logic        m_block_start,
    output logic [22:0] lfsr_state,
    output logic        err_align,
    output logic        err_sync
);

    typedef enum logic [2:0] {
        BLK_DATA  = 3'd0,
        BLK_OS    = 3'd1,
        BLK_SKP   = 3'd2,
        BLK_EIEOS = 3'd3,
        BLK_BAD   = 3'd4
    } blk_t;

    // Lane seeds repeat every eight lanes.
    function automatic logic [22:0] seed_lookup(input int idx);
        case (idx)
            0:       seed_lookup = 23'h1DBFBC;
            1:       seed_lookup = 23'h0607BB;
            2:       seed_lookup = 23'h1EC760;
            3:       seed_lookup = 23'h18C0DB;
            4:       seed_lookup = 23'h010F12;
            5:       seed_lookup = 23'h19CFC9;
            6:       seed_lookup = 23'h0277CE;
            default: seed_lookup = 23'h1BB807;
        endcase
    endfunction

    localparam logic [22:0] SEED = seed_lookup(LANE_NUM % 8);

    // Taps of X^21+X^16+X^8+X^5+X^2+1; X^23 is the bit shifted out of the top.
    localparam logic [22:0] TAPS = 23'h210125;

    // Eight serial steps of the Galois form of G(X), unrolled by synthesis.
    function automatic logic [22:0] lfsr_adv8(input logic [22:0] s);
        logic [22:0] r;
        logic        fb;
        r = s;
        for (int k = 0; k < 8; k++) begin
            fb = r[22];
            r  = {r[21:0], 1'b0} ^ (fb ? TAPS : 23'h0);
        end
        return r;
    endfunction

    logic [22:0] lfsr;
    logic [3:0]  byte_cnt;
    blk_t        blk_type;

    logic        xfer;
    logic [3:0]  pos;
    blk_t        hdr_type;
    blk_t        cur_type;
    logic        sync_bad;
    logic        scr_en;
    logic [7:0]  scr_byte;
    logic [22:0] lfsr_next;

    assign s_ready    = !m_valid || m_ready;
    assign xfer       = s_valid && s_ready;
    assign lfsr_state = lfsr;

    // Per-byte decision: effective position, block type and LFSR action.
    always_comb begin
        pos       = s_block_start ? 4'd0 : byte_cnt;
        sync_bad  = 1'b0;
        hdr_type  = BLK_BAD;
        scr_en    = 1'b0;
        lfsr_next = lfsr;
        for (int i = 0; i < 8; i++) begin
            scr_byte[i] = lfsr[22 - i];
        end

        if (s_sync == 2'b10) begin
            hdr_type = BLK_DATA;
        end else if (s_sync == 2'b01) begin
            if (s_data == 8'hAA) begin
                hdr_type = BLK_SKP;
            end else if (s_data == 8'h00) begin
                hdr_type = BLK_EIEOS;
            end else begin
                hdr_type = BLK_OS;
            end
        end else begin
            hdr_type = BLK_BAD;
            sync_bad = 1'b1;
        end

        cur_type = (pos == 4'd0) ? hdr_type : blk_type;

        case (cur_type)
            BLK_DATA: begin
                scr_en    = 1'b1;
                lfsr_next = lfsr_adv8(lfsr);
            end
            BLK_OS: begin
                scr_en    = (pos != 4'd0);
                lfsr_next = lfsr_adv8(lfsr);
            end
            BLK_EIEOS: begin
                lfsr_next = (pos == 4'd15) ? SEED : lfsr_adv8(lfsr);
            end
            default: begin
                lfsr_next = lfsr;
            end
        endcase

        if (cfg_scramble_disable) begin
            scr_en = 1'b0;
        end
    end

    // Sequencing state: LFSR, byte position and latched block type.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr     <= SEED;
            byte_cnt <= 4'd0;
            blk_type <= BLK_DATA;
        end else if (xfer) begin
            lfsr     <= lfsr_next;
            byte_cnt <= pos + 4'd1;
            if (pos == 4'd0) begin
                blk_type <= hdr_type;
            end
        end
    end

    // Output register with one-cycle error pulses tied to the accepted byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid       <= 1'b0;
            m_data        <= 8'h00;
            m_sync        <= 2'b00;
            m_block_start <= 1'b0;
            err_align     <= 1'b0;
            err_sync      <= 1'b0;
        end else begin
            err_align <= xfer && s_block_start && (byte_cnt != 4'd0);
            err_sync  <= xfer && (pos == 4'd0) && sync_bad;
            if (xfer) begin
                m_valid       <= 1'b1;
                m_data        <= scr_en ? (s_data ^ scr_byte) : s_data;
                m_sync        <= s_sync;
                m_block_start <= s_block_start;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gen3_scramble_ctrl.sv
// Bench for gen3_scramble_ctrl: reference model drives an expected queue,
// output bytes are popped and compared as the DUT hands them downstream.
module tb_gen3_scramble_ctrl;

    localparam logic [22:0] SEED0 = 23'h1DBFBC;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_scramble_disable;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic [1:0]  s_sync;
    logic        s_block_start;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic [1:0]  m_sync;
    logic        m_block_start;
    logic [22:0] lfsr_state;
    logic        err_align;
    logic        err_sync;

    gen3_scramble_ctrl #(.LANE_NUM(0)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .cfg_scramble_disable (cfg_scramble_disable),
        .s_valid              (s_valid),
        .s_ready              (s_ready),
        .s_data               (s_data),
        .s_sync               (s_sync),
        .s_block_start        (s_block_start),
        .m_valid              (m_valid),
        .m_ready              (m_ready),
        .m_data               (m_data),
        .m_sync               (m_sync),
        .m_block_start        (m_block_start),
        .lfsr_state           (lfsr_state),
        .err_align            (err_align),
        .err_sync             (err_sync)
    );

    // Clock
    always #5 clk = ~clk;

    // Scoreboard state
    logic [10:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    bit          stall_en = 0;

    // Reference model state
    logic [22:0] ref_lfsr;
    logic [3:0]  ref_cnt;
    int          ref_type;   // 0 data, 1 os, 2 skp, 3 eieos, 4 bad
    logic        ref_align;
    logic        ref_sync_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Serial form written with explicit tap positions of G(X).
    function automatic logic [22:0] ref_adv8(input logic [22:0] s);
        logic [22:0] r;
        logic        top;
        r = s;
        for (int k = 0; k < 8; k++) begin
            top = r[22];
            r = r << 1;
            if (top) begin
                r[0]  = ~r[0];
                r[2]  = ~r[2];
                r[5]  = ~r[5];
                r[8]  = ~r[8];
                r[16] = ~r[16];
                r[21] = ~r[21];
            end
        end
        return r;
    endfunction

    function automatic logic [22:0] ref_adv_n(input logic [22:0] s, input int n);
        logic [22:0] r;
        r = s;
        for (int k = 0; k < n; k++) r = ref_adv8(r);
        return r;
    endfunction

    // Model one accepted byte; pushes the expected output word.
    task automatic model_byte(input logic [7:0] d, input logic [1:0] sy, input logic bs);
        logic [3:0] p;
        logic [7:0] sb;
        logic       scr;
        logic [7:0] o;
        p = bs ? 4'd0 : ref_cnt;
        ref_align    = bs && (ref_cnt != 4'd0);
        ref_sync_err = 1'b0;
        if (p == 4'd0) begin
            if (sy == 2'b10) ref_type = 0;
            else if (sy == 2'b01) ref_type = (d == 8'hAA) ? 2 : ((d == 8'h00) ? 3 : 1);
            else begin
                ref_type = 4;
                ref_sync_err = 1'b1;
            end
        end
        for (int i = 0; i < 8; i++) sb[i] = ref_lfsr[22 - i];
        scr = ((ref_type == 0) || (ref_type == 1 && p != 4'd0)) && !cfg_scramble_disable;
        o = scr ? (d ^ sb) : d;
        exp_q.push_back({sy, bs, o});
        if (ref_type == 0 || ref_type == 1) ref_lfsr = ref_adv8(ref_lfsr);
        else if (ref_type == 3) ref_lfsr = (p == 4'd15) ? SEED0 : ref_adv8(ref_lfsr);
        ref_cnt = p + 4'd1;
    endtask

    // One clock of stimulus plus scoreboard bookkeeping.
    task automatic cycle(input bit v, input logic [7:0] d, input logic [1:0] sy,
                         input bit bs, output bit acc);
        bit          in_x;
        bit          out_x;
        logic [10:0] e;
        @(negedge clk);
        s_valid       = v;
        s_data        = d;
        s_sync        = sy;
        s_block_start = bs;
        m_ready       = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        #1;
        in_x  = s_valid && s_ready;
        out_x = m_valid && m_ready;
        if (out_x) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {21'h0, m_sync, m_block_start, m_data}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("out_word", {21'h0, m_sync, m_block_start, m_data}, {21'h0, e});
            end
        end
        ref_align    = 1'b0;
        ref_sync_err = 1'b0;
        if (in_x) model_byte(d, sy, bs);
        @(posedge clk);
        #1;
        check("lfsr_state", {9'h0, lfsr_state}, {9'h0, ref_lfsr});
        check("err_align", {31'h0, err_align}, {31'h0, ref_align});
        check("err_sync", {31'h0, err_sync}, {31'h0, ref_sync_err});
        acc = in_x;
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] sy, input bit bs);
        bit acc;
        int tries;
        if (stall_en && $urandom_range(0, 2) == 0) cycle(1'b0, 8'h00, 2'b00, 1'b0, acc);
        acc   = 0;
        tries = 0;
        while (!acc && tries < 100) begin
            cycle(1'b1, d, sy, bs, acc);
            tries++;
        end
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    // Block of 16 bytes; byte 0 supplied, rest from pattern selector.
    task automatic send_block(input logic [1:0] sy, input logic [7:0] b0, input int pat);
        logic [7:0] d;
        send(b0, sy, 1'b1);
        for (int i = 1; i < 16; i++) begin
            case (pat)
                0: d = 8'h00;
                1: d = (i < 8) ? 8'h00 : 8'hFF;
                2: d = 8'hAA;
                default: d = 8'($urandom_range(0, 255));
            endcase
            send(d, sy, 1'b0);
        end
    endtask

    task automatic drain;
        bit acc;
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < 64) begin
            cycle(1'b0, 8'h00, 2'b00, 1'b0, acc);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst     = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        ref_lfsr = SEED0;
        ref_cnt  = 4'd0;
        ref_type = 0;
        check("rst_lfsr", {9'h0, lfsr_state}, {9'h0, SEED0});
        check("rst_outputs", {21'h0, m_valid, m_data, m_sync, m_block_start},
              32'h0);
        check("rst_errs", {30'h0, err_align, err_sync}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [22:0] saved;

    initial begin
        rst = 1'b1;
        cfg_scramble_disable = 1'b0;
        s_valid = 1'b0;
        s_data = 8'h00;
        s_sync = 2'b10;
        s_block_start = 1'b0;
        m_ready = 1'b1;
        do_reset();

        // 1: DATA block of zeros
        send(8'h00, 2'b10, 1'b1);
        check("t1_first_byte", {24'h0, m_data}, 32'h0000_00DC);
        check("t1_lfsr_after0", {9'h0, lfsr_state}, {9'h0, ref_adv8(SEED0)});
        for (int i = 1; i < 16; i++) send(8'h00, 2'b10, 1'b0);

        // 2: OS block after DATA
        saved = ref_lfsr;
        send_block(2'b01, 8'hE1, 3);
        check("t2_os_adv16", {9'h0, lfsr_state}, {9'h0, ref_adv_n(saved, 16)});

        // 3: SKP between DATA blocks
        send_block(2'b10, 8'h5A, 3);
        saved = lfsr_state;
        send_block(2'b01, 8'hAA, 2);
        check("t3_skp_hold", {9'h0, lfsr_state}, {9'h0, saved});
        send_block(2'b10, 8'h00, 0);

        // 4: EIEOS reseeds, then DATA restarts from seed
        send_block(2'b01, 8'h00, 1);
        check("t4_eieos_seed", {9'h0, lfsr_state}, {9'h0, SEED0});
        send(8'h00, 2'b10, 1'b1);
        check("t4_restart_dc", {24'h0, m_data}, 32'h0000_00DC);
        for (int i = 1; i < 16; i++) send(8'h00, 2'b10, 1'b0);
        drain();

        // 5: random stalls over 64 mixed blocks
        stall_en = 1;
        for (int b = 0; b < 64; b++) begin
            case ($urandom_range(0, 5))
                0:       send_block(2'b01, 8'hAA, 2);
                1:       send_block(2'b01, 8'h00, 1);
                2:       send_block(2'b01, 8'(($urandom_range(1, 254) == 8'hAA) ? 8'h2D : $urandom_range(1, 254)), 3);
                default: send_block(2'b10, 8'($urandom_range(0, 255)), 3);
            endcase
        end
        drain();
        stall_en = 0;

        // 6: misaligned block_start, bad sync header, scramble disable
        for (int i = 0; i < 7; i++) send(8'($urandom_range(0, 255)), 2'b10, (i == 0));
        send(8'h11, 2'b10, 1'b1);
        check("t6_align_pulse", {31'h0, err_align}, 32'd1);
        for (int i = 1; i < 16; i++) send(8'($urandom_range(0, 255)), 2'b10, 1'b0);
        check("t6_align_cleared", {31'h0, err_align}, 32'd0);
        saved = lfsr_state;
        send(8'h3C, 2'b11, 1'b1);
        check("t6_sync_pulse", {31'h0, err_sync}, 32'd1);
        check("t6_bad_passthru", {24'h0, m_data}, 32'h0000_003C);
        for (int i = 1; i < 16; i++) send(8'($urandom_range(0, 255)), 2'b11, 1'b0);
        check("t6_bad_hold", {9'h0, lfsr_state}, {9'h0, saved});
        cfg_scramble_disable = 1'b1;
        saved = lfsr_state;
        send(8'h77, 2'b10, 1'b1);
        check("t6_dis_passthru", {24'h0, m_data}, 32'h0000_0077);
        for (int i = 1; i < 16; i++) send(8'($urandom_range(0, 255)), 2'b10, 1'b0);
        check("t6_dis_adv16", {9'h0, lfsr_state}, {9'h0, ref_adv_n(saved, 16)});
        cfg_scramble_disable = 1'b0;
        drain();

        // Reset mid-block, then a fresh block
        for (int i = 0; i < 5; i++) send(8'h42, 2'b10, (i == 0));
        do_reset();
        send(8'h00, 2'b10, 1'b1);
        check("rst_mid_first", {24'h0, m_data}, 32'h0000_00DC);
        for (int i = 1; i < 16; i++) send(8'h00, 2'b10, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
